// File: rtl/sample_capture_buf_if.sv
// rtl/sample_capture_buf_if.sv - replay stream port of the capture buffer
interface sample_capture_buf_if #(
  parameter int DW = 32
);
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sample_capture_buf.sv
// rtl/sample_capture_buf.sv - pre/post-trigger ring capture of the rle_enc word stream
// with oldest-first replay over a valid/ready port.
module sample_capture_buf #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 arm,
  input  logic                 trigger,
  input  logic [AW:0]          post_count,
  input  logic [DW-1:0]        dataIn,
  input  logic                 validIn,
  sample_capture_buf_if.master rd,
  output logic                 busy,
  output logic                 done,
  output logic [AW:0]          fill
);
  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW + 1)'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_READ  = 2'd3;

  logic [DW-1:0] mem [DEPTH];
  logic [1:0]    state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   post_cnt;
  logic [AW:0]   rd_left;
  logic          rd_init;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          wr_en;

  assign wr_en = validIn && !arm &&
                 (state == ST_ARMED || (state == ST_POST && post_cnt != '0));
  assign busy         = (state != ST_IDLE);
  assign rd.out_data  = out_data;
  assign rd.out_valid = out_valid;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= dataIn;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      post_cnt  <= '0;
      rd_left   <= '0;
      rd_init   <= 1'b0;
      fill      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (arm) begin
        // Arm aborts whatever is running and wins over a same-cycle trigger.
        state     <= ST_ARMED;
        wr_ptr    <= '0;
        fill      <= '0;
        out_valid <= 1'b0;
        rd_init   <= 1'b0;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (fill != DEPTH_W) begin
            fill <= fill + 1'b1;
          end
        end
        case (state)
          ST_ARMED: begin
            if (trigger) begin
              state    <= ST_POST;
              post_cnt <= post_count;
            end
          end
          ST_POST: begin
            if (post_cnt == '0) begin
              state   <= ST_READ;
              rd_init <= 1'b1;
            end else if (validIn) begin
              post_cnt <= post_cnt - 1'b1;
              if (post_cnt == ONE_W) begin
                state   <= ST_READ;
                rd_init <= 1'b1;
              end
            end
          end
          ST_READ: begin
            if (rd_init) begin
              // Oldest word sits fill entries behind the write pointer (mod DEPTH).
              rd_init <= 1'b0;
              rd_ptr  <= wr_ptr - fill[AW-1:0];
              rd_left <= fill;
              if (fill == '0) begin
                done  <= 1'b1;
                state <= ST_IDLE;
              end
            end else if (out_valid && rd.out_ready && rd_left == '0) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= ST_IDLE;
            end else if ((!out_valid || rd.out_ready) && rd_left != '0) begin
              out_data  <= mem[rd_ptr];
              out_valid <= 1'b1;
              rd_ptr    <= rd_ptr + 1'b1;
              rd_left   <= rd_left - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sample_capture_buf.sv
// tb/tb_sample_capture_buf.sv - directed self-checking bench for sample_capture_buf
module tb_sample_capture_buf;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          arm = 1'b0;
  logic          trigger = 1'b0;
  logic [AW:0]   post_count = '0;
  logic [DW-1:0] dataIn = '0;
  logic          validIn = 1'b0;
  logic          busy;
  logic          done;
  logic [AW:0]   fill;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q [$];

  sample_capture_buf_if #(.DW(DW)) bus ();

  sample_capture_buf #(.DW(DW), .AW(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .arm        (arm),
    .trigger    (trigger),
    .post_count (post_count),
    .dataIn     (dataIn),
    .validIn    (validIn),
    .rd         (bus),
    .busy       (busy),
    .done       (done),
    .fill       (fill)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic do_trigger(input int pc);
    trigger = 1'b1;
    post_count = (AW + 1)'(pc);
    step();
    trigger = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] d);
    dataIn = d;
    validIn = 1'b1;
    step();
    validIn = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.out_valid && n < 40) begin
      step();
      n++;
    end
    check(tag, 32'(bus.out_valid), 32'd1);
  endtask

  // Replays exp_q; when stall_at matches a word index, holds out_ready low for 5 cycles first.
  task automatic replay(input string tag, input int stall_at);
    bus.out_ready = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      wait_valid({tag, "_valid"});
      if (i == stall_at) begin
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          step();
          check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
          check({tag, "_hold_data"}, bus.out_data, exp_q[i]);
        end
        bus.out_ready = 1'b1;
      end
      check({tag, "_data"}, bus.out_data, exp_q[i]);
      step();
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_valid_low"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    step();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.out_ready = 1'b0;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", bus.out_data, 32'd0);
    reset = 1'b0;
    step();

    // Trigger and writes in IDLE are ignored
    dataIn = 32'h77;
    validIn = 1'b1;
    do_trigger(3);
    validIn = 1'b0;
    step();
    check("idle_trig_busy", 32'(busy), 32'd0);
    check("idle_trig_fill", 32'(fill), 32'd0);

    // 1: basic pre/post capture
    do_arm();
    check("t1_busy", 32'(busy), 32'd1);
    for (int i = 1; i <= 5; i++) write_word(32'(i));
    do_trigger(3);
    for (int i = 6; i <= 8; i++) write_word(32'(i));
    check("t1_fill", 32'(fill), 32'd8);
    exp_q.delete();
    for (int i = 1; i <= 8; i++) exp_q.push_back(32'(i));
    replay("t1", -1);
    check("t1_fill_kept", 32'(fill), 32'd8);

    // 2: wrap-around keeps the last 16 words
    do_arm();
    for (int i = 0; i <= 35; i++) write_word(32'(i));
    do_trigger(4);
    for (int i = 36; i <= 39; i++) write_word(32'(i));
    check("t2_fill", 32'(fill), 32'd16);
    exp_q.delete();
    for (int i = 24; i <= 39; i++) exp_q.push_back(32'(i));
    replay("t2", -1);

    // 3: validIn gaps
    do_arm();
    for (int i = 0; i < 8; i++) begin
      dataIn = 32'(100 + i);
      validIn = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    validIn = 1'b0;
    check("t3_fill", 32'(fill), 32'd4);
    do_trigger(0);
    exp_q.delete();
    exp_q.push_back(32'd100);
    exp_q.push_back(32'd103);
    exp_q.push_back(32'd104);
    exp_q.push_back(32'd107);
    replay("t3", -1);

    // 4: backpressure mid-replay
    do_arm();
    for (int i = 200; i <= 205; i++) write_word(32'(i));
    do_trigger(2);
    write_word(32'd206);
    write_word(32'd207);
    exp_q.delete();
    for (int i = 200; i <= 207; i++) exp_q.push_back(32'(i));
    replay("t4", 3);

    // 5: post_count=0 replays pre-trigger words only
    do_arm();
    write_word(32'd50);
    write_word(32'd51);
    dataIn = 32'd52;
    validIn = 1'b1;
    do_trigger(0);
    validIn = 1'b0;
    check("t5_fill", 32'(fill), 32'd3);
    step();
    check("t5_fill_post", 32'(fill), 32'd3);
    exp_q.delete();
    exp_q.push_back(32'd50);
    exp_q.push_back(32'd51);
    exp_q.push_back(32'd52);
    replay("t5", -1);

    // 5b: arm and trigger together stay ARMED
    arm = 1'b1;
    trigger = 1'b1;
    post_count = '0;
    step();
    arm = 1'b0;
    trigger = 1'b0;
    write_word(32'd60);
    step();
    step();
    step();
    check("t5b_busy", 32'(busy), 32'd1);
    check("t5b_valid", 32'(bus.out_valid), 32'd0);
    check("t5b_fill", 32'(fill), 32'd1);
    do_trigger(0);
    exp_q.delete();
    exp_q.push_back(32'd60);
    replay("t5b", -1);

    // 6: reset mid-READ, then re-arm
    do_arm();
    for (int i = 1; i <= 4; i++) write_word(32'(i));
    do_trigger(0);
    bus.out_ready = 1'b0;
    wait_valid("t6_pre_valid");
    reset = 1'b1;
    #1;
    check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_fill", 32'(fill), 32'd0);
    step();
    reset = 1'b0;
    step();
    do_arm();
    write_word(32'hA5);
    do_trigger(0);
    exp_q.delete();
    exp_q.push_back(32'hA5);
    replay("t6", -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
